// File: rtl/linebuf_window9_pkg.sv
// Shared defaults and types for the 9x9 streaming window generator.
// The top exposes these as overridable parameters so smaller geometries can be built.
package linebuf_pkg;

  localparam int PIX_W  = 7;
  localparam int WIN    = 9;
  localparam int IMG_W  = 28;
  localparam int IMG_H  = 28;
  localparam int N_TAPS = WIN * WIN;

  typedef logic [PIX_W-1:0] pix_t;

  // Flat tap number of window row r, column c (row 0 oldest, column 0 oldest).
  function automatic int tapIndex(input int r, input int c, input int win);
    return r * win + c;
  endfunction

endpackage

// File: rtl/linebuf_window9_line_fifo.sv
// One image-line delay: a circular buffer whose single pointer serves both the read and
// the write, so the output is always the pixel written DEPTH accepts earlier.
module line_fifo #(
  parameter int DEPTH = linebuf_pkg::IMG_W,
  parameter int PIX_W = linebuf_pkg::PIX_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [PIX_W-1:0] pix_i,
  output logic [PIX_W-1:0] pix_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Storage is deliberately never cleared; the window valid gating hides stale lines.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      mem_q[ptr_q] <= pix_i;
    end
  end

  assign pix_o = mem_q[ptr_q];

endmodule

// File: rtl/linebuf_window9.sv
// Raster-order pixel stream in, every complete stride-1 WIN x WIN window out as a flat
// 81-tap bus with a one-cycle valid pulse and its top-left coordinate.
module linebuf_window9 #(
  parameter int PIX_W = linebuf_pkg::PIX_W,
  parameter int WIN   = linebuf_pkg::WIN,
  parameter int IMG_W = linebuf_pkg::IMG_W,
  parameter int IMG_H = linebuf_pkg::IMG_H
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic                       in_sof,
  input  logic [PIX_W-1:0]           in_pix,
  output logic                       win_valid,
  output logic [WIN*WIN*PIX_W-1:0]   win_flat,
  output logic [$clog2(IMG_H)-1:0]   win_row,
  output logic [$clog2(IMG_W)-1:0]   win_col,
  output logic                       frame_done
);

  import linebuf_pkg::*;

  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);
  localparam int TAPS  = WIN * WIN;

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(WIN - 1);
  localparam logic [COL_W-1:0] COL_MIN  = COL_W'(WIN - 1);

  logic             accept;
  logic [ROW_W-1:0] curRow;
  logic [COL_W-1:0] curCol;
  logic             windowHit;
  logic             lastPix;

  logic [ROW_W-1:0] rowCnt_q, rowCnt_d;
  logic [COL_W-1:0] colCnt_q, colCnt_d;

  logic [PIX_W-1:0] fifoIn  [WIN-1];
  logic [PIX_W-1:0] fifoOut [WIN-1];
  logic [PIX_W-1:0] newCol  [WIN];

  logic [PIX_W-1:0] win_q [TAPS];
  logic [PIX_W-1:0] win_d [TAPS];

  logic             winValid_q, winValid_d;
  logic             frameDone_q, frameDone_d;
  logic [ROW_W-1:0] winRow_q, winRow_d;
  logic [COL_W-1:0] winCol_q, winCol_d;

  assign accept = in_valid & rst_n;

  // A start-of-frame beat is treated as pixel (0,0) whatever the counters say.
  always_comb begin
    curRow    = in_sof ? '0 : rowCnt_q;
    curCol    = in_sof ? '0 : colCnt_q;
    windowHit = accept && (curRow >= ROW_MIN) && (curCol >= COL_MIN);
    lastPix   = accept && (curRow == ROW_LAST) && (curCol == COL_LAST);
  end

  always_comb begin
    rowCnt_d = rowCnt_q;
    colCnt_d = colCnt_q;
    if (accept) begin
      if (curCol == COL_LAST) begin
        colCnt_d = '0;
        rowCnt_d = (curRow == ROW_LAST) ? '0 : curRow + 1'b1;
      end else begin
        colCnt_d = curCol + 1'b1;
        rowCnt_d = curRow;
      end
    end
  end

  for (genvar g = 0; g < WIN - 1; g++) begin : gLine
    if (g == 0) begin : gHead
      assign fifoIn[g] = in_pix;
    end else begin : gChain
      assign fifoIn[g] = fifoOut[g-1];
    end

    line_fifo #(
      .DEPTH (IMG_W),
      .PIX_W (PIX_W)
    ) uLine (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .en_i   (accept),
      .pix_i  (fifoIn[g]),
      .pix_o  (fifoOut[g])
    );

    // Deeper FIFOs hold older lines, so they land nearer the top of the column.
    assign newCol[WIN-2-g] = fifoOut[g];
  end

  assign newCol[WIN-1] = in_pix;

  always_comb begin
    for (int i = 0; i < TAPS; i++) begin
      win_d[i] = win_q[i];
    end
    if (accept) begin
      for (int r = 0; r < WIN; r++) begin
        for (int c = 0; c < WIN - 1; c++) begin
          win_d[tapIndex(r, c, WIN)] = win_q[tapIndex(r, c + 1, WIN)];
        end
        win_d[tapIndex(r, WIN - 1, WIN)] = newCol[r];
      end
    end
  end

  always_comb begin
    winValid_d  = windowHit;
    frameDone_d = lastPix;
    winRow_d    = windowHit ? curRow - ROW_MIN : winRow_q;
    winCol_d    = windowHit ? curCol - COL_MIN : winCol_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rowCnt_q    <= '0;
      colCnt_q    <= '0;
      winValid_q  <= 1'b0;
      frameDone_q <= 1'b0;
      winRow_q    <= '0;
      winCol_q    <= '0;
      for (int i = 0; i < TAPS; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      rowCnt_q    <= rowCnt_d;
      colCnt_q    <= colCnt_d;
      winValid_q  <= winValid_d;
      frameDone_q <= frameDone_d;
      winRow_q    <= winRow_d;
      winCol_q    <= winCol_d;
      for (int i = 0; i < TAPS; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  for (genvar t = 0; t < TAPS; t++) begin : gFlat
    assign win_flat[t*PIX_W +: PIX_W] = win_q[t];
  end

  assign win_valid  = winValid_q;
  assign frame_done = frameDone_q;
  assign win_row    = winRow_q;
  assign win_col    = winCol_q;

endmodule

// File: tb/tb_linebuf_window9.sv
// Self-checking bench: a default 28x28/9x9 instance and a small 12x10/3x3 instance, both
// compared every cycle against a frame-image reference model plus directed tap checks.
module tb_linebuf_window9;

  import linebuf_pkg::*;

  localparam int FW  = N_TAPS * PIX_W;
  localparam int BW  = 3;
  localparam int BIW = 12;
  localparam int BIH = 10;
  localparam int BFW = BW * BW * PIX_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n = 1'b0;
  logic             vA = 1'b0, sA = 1'b0, vB = 1'b0, sB = 1'b0;
  pix_t             pA = '0, pB = '0;

  logic             wvA, fdA, wvB, fdB;
  logic [FW-1:0]    wfA;
  logic [BFW-1:0]   wfB;
  logic [4:0]       wrA, wcA;
  logic [3:0]       wrB, wcB;

  linebuf_window9 dutA (
    .clk(clk), .rst_n(rst_n), .in_valid(vA), .in_sof(sA), .in_pix(pA),
    .win_valid(wvA), .win_flat(wfA), .win_row(wrA), .win_col(wcA), .frame_done(fdA)
  );

  linebuf_window9 #(.PIX_W(PIX_W), .WIN(BW), .IMG_W(BIW), .IMG_H(BIH)) dutB (
    .clk(clk), .rst_n(rst_n), .in_valid(vB), .in_sof(sB), .in_pix(pB),
    .win_valid(wvB), .win_flat(wfB), .win_row(wrB), .win_col(wcB), .frame_done(fdB)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: the current frame as a 2-D image, windows cut straight out of it.
  int            mRow [2];
  int            mCol [2];
  int            img [2][28][28];
  logic [FW-1:0] eFlat [2];
  int            eRow [2];
  int            eCol [2];
  bit            eValid [2];
  bit            eDone [2];
  bit            known [2];

  int            accCnt [2];
  int            mark [2];
  int            firstGap [2];
  bit            firstSeen [2];
  int            pulses [2];
  logic [FW-1:0] firstFlat [2];
  logic [FW-1:0] lastFlat [2];
  int            firstRow [2], firstCol [2], lastRow [2], lastCol [2];

  typedef struct {
    int tap;
    int val;
  } tapVec_t;
  tapVec_t tv [4];

  task automatic cmpInt(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic cmpFlat(input int d, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL dut%0d win_flat: got %h want %h", d, act, exp);
    end
  endtask

  task automatic modelStep(input int d, input bit rn, input bit v, input bit sof, input int pix);
    int w, iw, ih, r, c;
    w  = (d == 0) ? WIN : BW;
    iw = (d == 0) ? IMG_W : BIW;
    ih = (d == 0) ? IMG_H : BIH;
    if (!rn) begin
      eValid[d] = 0; eDone[d] = 0; eFlat[d] = '0; eRow[d] = 0; eCol[d] = 0;
      known[d] = 1; mRow[d] = 0; mCol[d] = 0;
    end else if (v) begin
      r = sof ? 0 : mRow[d];
      c = sof ? 0 : mCol[d];
      img[d][r][c] = pix & 127;
      accCnt[d]++;
      eDone[d] = (r == ih - 1) && (c == iw - 1);
      if (r >= w - 1 && c >= w - 1) begin
        eValid[d] = 1; known[d] = 1;
        eRow[d] = r - w + 1; eCol[d] = c - w + 1;
        eFlat[d] = '0;
        for (int i = 0; i < w; i++)
          for (int j = 0; j < w; j++)
            eFlat[d][(i*w + j)*PIX_W +: PIX_W] = PIX_W'(img[d][eRow[d]+i][eCol[d]+j]);
      end else begin
        eValid[d] = 0; known[d] = 0;
      end
      if (c == iw - 1) begin
        mCol[d] = 0;
        mRow[d] = (r == ih - 1) ? 0 : r + 1;
      end else begin
        mCol[d] = c + 1;
        mRow[d] = r;
      end
    end else begin
      eValid[d] = 0; eDone[d] = 0;
    end
  endtask

  task automatic checkOutput(input int d);
    bit            aV, aD;
    logic [FW-1:0] aF;
    int            aR, aC;
    if (d == 0) begin
      aV = wvA; aD = fdA; aF = wfA; aR = int'(wrA); aC = int'(wcA);
    end else begin
      aV = wvB; aD = fdB; aF = FW'(wfB); aR = int'(wrB); aC = int'(wcB);
    end
    cmpInt($sformatf("dut%0d win_valid", d), int'(aV), int'(eValid[d]));
    cmpInt($sformatf("dut%0d frame_done", d), int'(aD), int'(eDone[d]));
    if (known[d]) begin
      cmpFlat(d, aF, eFlat[d]);
      cmpInt($sformatf("dut%0d win_row", d), aR, eRow[d]);
      cmpInt($sformatf("dut%0d win_col", d), aC, eCol[d]);
    end
    if (aV) begin
      pulses[d]++;
      if (!firstSeen[d]) begin
        firstSeen[d] = 1;
        firstGap[d]  = accCnt[d] - mark[d];
        firstFlat[d] = aF; firstRow[d] = aR; firstCol[d] = aC;
      end
      lastFlat[d] = aF; lastRow[d] = aR; lastCol[d] = aC;
    end
  endtask

  task automatic applyStimulus(input int d, input bit rn, input bit v, input bit sof, input int pix);
    @(negedge clk);
    rst_n = rn;
    vA = (d == 0) ? v : 1'b0;
    sA = (d == 0) ? sof : 1'b0;
    pA = (d == 0) ? PIX_W'(pix) : '0;
    vB = (d == 1) ? v : 1'b0;
    sB = (d == 1) ? sof : 1'b0;
    pB = (d == 1) ? PIX_W'(pix) : '0;
    modelStep(d, rn, v, sof, pix);
    modelStep(1 - d, rn, 1'b0, 1'b0, 0);
    @(posedge clk);
    #1;
    checkOutput(d);
    if (!rn) checkOutput(1 - d);
  endtask

  task automatic markStart(input int d);
    mark[d] = accCnt[d];
    firstSeen[d] = 0;
    pulses[d] = 0;
  endtask

  task automatic runFrame(input int d, input int off, input bit randValid, input bit useSof,
                          input int nPix, input bit randPix);
    int pix, g;
    for (int p = 0; p < nPix; p++) begin
      g = 0;
      while (randValid && g < 4 && $urandom_range(0, 1) == 1) begin
        applyStimulus(d, 1'b1, 1'b0, 1'b0, int'($urandom_range(0, 127)));
        g++;
      end
      pix = randPix ? int'($urandom_range(0, 126)) : (p + off) % 128;
      applyStimulus(d, 1'b1, 1'b1, useSof && (p == 0), pix);
    end
  endtask

  initial begin
    int n3;
    tv[0] = '{tap: 0,  val: 0};
    tv[1] = '{tap: 8,  val: 8};
    tv[2] = '{tap: 72, val: 96};
    tv[3] = '{tap: 80, val: 104};
    for (int d = 0; d < 2; d++) begin
      accCnt[d] = 0; mRow[d] = 0; mCol[d] = 0; known[d] = 0;
      for (int r = 0; r < 28; r++)
        for (int c = 0; c < 28; c++)
          img[d][r][c] = 0;
    end

    $display("[TB] reset");
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(0, 1'b0, 1'b1, 1'b1, 5);

    $display("[TB] frame 1: continuous ramp");
    markStart(0);
    runFrame(0, 0, 1'b0, 1'b1, 784, 1'b0);
    cmpInt("frame1 pulses", pulses[0], 400);
    cmpInt("frame1 accepts to first window", firstGap[0], 233);
    cmpInt("frame1 first win_row", firstRow[0], 0);
    cmpInt("frame1 first win_col", firstCol[0], 0);
    for (int i = 0; i < 4; i++)
      cmpInt($sformatf("frame1 first tap%0d", tv[i].tap),
             int'(firstFlat[0][tv[i].tap*PIX_W +: PIX_W]), tv[i].val);
    cmpInt("frame1 last win_row", lastRow[0], 19);
    cmpInt("frame1 last win_col", lastCol[0], 19);
    cmpInt("frame1 last tap80", int'(lastFlat[0][80*PIX_W +: PIX_W]), 15);

    $display("[TB] frame 2: ramp with random valid gaps");
    markStart(0);
    runFrame(0, 0, 1'b1, 1'b1, 784, 1'b0);
    cmpInt("frame2 pulses", pulses[0], 400);
    cmpInt("frame2 last win_row", lastRow[0], 19);

    $display("[TB] frames 3 and 4: back to back, second offset by 64");
    markStart(0);
    runFrame(0, 0, 1'b0, 1'b1, 784, 1'b0);
    n3 = pulses[0];
    markStart(0);
    runFrame(0, 64, 1'b0, 1'b1, 784, 1'b0);
    cmpInt("two-frame pulses", n3 + pulses[0], 800);
    cmpInt("frame4 first win_row", firstRow[0], 0);
    cmpInt("frame4 first win_col", firstCol[0], 0);
    cmpInt("frame4 first tap0", int'(firstFlat[0][0 +: PIX_W]), 64);

    $display("[TB] sof resync at pixel 300");
    runFrame(0, 0, 1'b0, 1'b1, 300, 1'b1);
    markStart(0);
    runFrame(0, 0, 1'b0, 1'b1, 784, 1'b1);
    cmpInt("resync accepts to first window", firstGap[0], 233);
    cmpInt("resync first win_row", firstRow[0], 0);
    cmpInt("resync first win_col", firstCol[0], 0);

    $display("[TB] reset mid-frame");
    runFrame(0, 127, 1'b0, 1'b1, 150, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 1'b1, 127);
    markStart(0);
    runFrame(0, 0, 1'b1, 1'b0, 784, 1'b1);
    cmpInt("post-reset accepts to first window", firstGap[0], 233);
    cmpInt("post-reset pulses", pulses[0], 400);

    $display("[TB] small geometry 12x10, 3x3");
    markStart(1);
    runFrame(1, 0, 1'b1, 1'b1, BIW * BIH, 1'b1);
    cmpInt("small frame1 pulses", pulses[1], 80);
    cmpInt("small accepts to first window", firstGap[1], 27);
    markStart(1);
    runFrame(1, 0, 1'b1, 1'b0, BIW * BIH, 1'b1);
    cmpInt("small frame2 pulses", pulses[1], 80);
    cmpInt("small last win_row", lastRow[1], 7);
    cmpInt("small last win_col", lastCol[1], 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
